// File: rtl/ram_master_pkg.sv
// ram_burst_master shared types.
// FSM state encoding and read pipeline depth.
package ram_master_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN
  } state_e;

  localparam int READ_LATENCY = 2;

endpackage

// File: rtl/ram_read_pipe.sv
// Read-return pipeline: tracks issued addresses
// and captures ram_Q once the RAM has answered.
module ram_read_pipe
  import ram_master_pkg::*;
#(
  parameter int DATAWIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 issue_i,
  input  logic [DATAWIDTH-1:0] q_i,
  output logic                 pend_o,
  output logic                 rd_valid_o,
  output logic [DATAWIDTH-1:0] rd_data_o
);

  logic [READ_LATENCY-1:0] v_q;
  logic                    rd_valid_q;
  logic [DATAWIDTH-1:0]    rd_data_q;

  // Shift issue flags; capture Q when the oldest one arrives.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v_q        <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      v_q        <= {v_q[READ_LATENCY-2:0], issue_i};
      rd_valid_q <= v_q[READ_LATENCY-1];
      if (v_q[READ_LATENCY-1]) begin
        rd_data_q <= q_i;
      end
    end
  end

  // High while reads remain beyond the one captured next edge.
  assign pend_o     = |v_q[READ_LATENCY-2:0];
  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;

endmodule

// File: rtl/ram_burst_master.sv
// Burst initiator for the synchronous RAM port.
// One write or read burst at a time, 2-cycle read latency.
module ram_burst_master
  import ram_master_pkg::*;
#(
  parameter int ADDRWIDTH = 12,
  parameter int DATAWIDTH = 8,
  parameter int LENWIDTH  = 8
) (
  input  logic                 CK,
  input  logic                 RST,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ADDRWIDTH-1:0] cmd_addr,
  input  logic [LENWIDTH-1:0]  cmd_len,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [DATAWIDTH-1:0] wr_data,
  output logic                 rd_valid,
  output logic [DATAWIDTH-1:0] rd_data,
  output logic                 done,
  output logic [ADDRWIDTH-1:0] ram_A,
  output logic                 ram_WE,
  output logic                 ram_OE,
  output logic [DATAWIDTH-1:0] ram_D,
  input  logic [DATAWIDTH-1:0] ram_Q
);

  localparam logic [ADDRWIDTH-1:0] A_ONE = 1;
  localparam logic [LENWIDTH-1:0]  L_ONE = 1;

  state_e               state_q;
  logic [ADDRWIDTH-1:0] addr_q;
  logic [LENWIDTH-1:0]  cnt_q;
  logic [ADDRWIDTH-1:0] ram_A_q;
  logic [DATAWIDTH-1:0] ram_D_q;
  logic                 we_q;
  logic                 oe_q;
  logic                 done_q;

  logic cmd_hs;
  logic wr_hs;
  logic issue;
  logic rd_pend;

  assign cmd_ready = (state_q == IDLE);
  assign wr_ready  = (state_q == WRITE);
  assign cmd_hs    = cmd_valid && cmd_ready;
  assign wr_hs     = wr_valid && wr_ready;

  // A read address goes out on every accepting or READ edge.
  assign issue = (cmd_hs && !cmd_write)
              || (state_q == READ);

  // Burst sequencer with registered RAM-side outputs.
  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      ram_A_q <= '0;
      ram_D_q <= '0;
      we_q    <= 1'b0;
      oe_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          we_q <= 1'b0;
          if (cmd_hs) begin
            cnt_q <= cmd_len;
            if (cmd_write) begin
              addr_q  <= cmd_addr;
              state_q <= WRITE;
            end else begin
              ram_A_q <= cmd_addr;
              addr_q  <= cmd_addr + A_ONE;
              oe_q    <= 1'b1;
              state_q <= (cmd_len == '0)
                       ? DRAIN : READ;
            end
          end
        end
        WRITE: begin
          we_q <= wr_hs;
          if (wr_hs) begin
            ram_A_q <= addr_q;
            ram_D_q <= wr_data;
            addr_q  <= addr_q + A_ONE;
            cnt_q   <= cnt_q - L_ONE;
            if (cnt_q == '0) begin
              state_q <= DRAIN;
            end
          end
        end
        READ: begin
          ram_A_q <= addr_q;
          addr_q  <= addr_q + A_ONE;
          cnt_q   <= cnt_q - L_ONE;
          if (cnt_q == L_ONE) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          we_q <= 1'b0;
          if (!rd_pend) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
            oe_q    <= 1'b0;
          end
        end
      endcase
    end
  end

  ram_read_pipe #(
    .DATAWIDTH (DATAWIDTH)
  ) u_rd_pipe (
    .clk_i      (CK),
    .rst_i      (RST),
    .issue_i    (issue),
    .q_i        (ram_Q),
    .pend_o     (rd_pend),
    .rd_valid_o (rd_valid),
    .rd_data_o  (rd_data)
  );

  assign ram_A  = ram_A_q;
  assign ram_D  = ram_D_q;
  assign ram_WE = we_q;
  assign ram_OE = oe_q;
  assign done   = done_q;

endmodule

// File: tb/tb_ram_burst_master.sv
// Self-checking bench for ram_burst_master with
// a behavioural RAM and a read scoreboard.
module tb_ram_burst_master;

  logic        CK;
  logic        RST;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [11:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_data;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        done;
  logic [11:0] ram_A;
  logic        ram_WE;
  logic        ram_OE;
  logic [7:0]  ram_D;
  logic [7:0]  ram_Q;

  int checks = 0;
  int errors = 0;

  ram_burst_master #(
    .ADDRWIDTH (12),
    .DATAWIDTH (8),
    .LENWIDTH  (8)
  ) dut (
    .CK        (CK),
    .RST       (RST),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .done      (done),
    .ram_A     (ram_A),
    .ram_WE    (ram_WE),
    .ram_OE    (ram_OE),
    .ram_D     (ram_D),
    .ram_Q     (ram_Q)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  // RAM model: write and address latch on posedge,
  // Q relatched on negedge.
  logic [7:0]  mem [0:4095];
  logic [11:0] a_lat;
  initial begin
    a_lat = '0;
    ram_Q = '0;
  end
  always @(posedge CK) begin
    if (ram_WE) mem[ram_A] <= ram_D;
    a_lat <= ram_A;
  end
  always @(negedge CK) ram_Q <= mem[a_lat];

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  // Write burst of d.size() words, wr_valid follows pat.
  task automatic run_write(
    input logic [11:0] a,
    input logic [7:0]  d[$],
    input int          pat[$]
  );
    logic [19:0] q[$];
    logic [19:0] e;
    logic [11:0] ea;
    logic        hs;
    int          n;
    int          idx;
    int          c;
    n = d.size();
    ea = a;
    idx = 0;
    c = 0;
    hs = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_cmd_ready got %b exp 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = a;
    cmd_len   = 8'(n - 1);
    tick();
    cmd_valid = 1'b0;
    while (idx < n && c < 64) begin
      checks++;
      if (ram_WE !== hs) begin
        errors++;
        $display("FAIL wr_we c=%0d got %b exp %b", c, ram_WE, hs);
      end
      if (hs) begin
        e = q.pop_front();
        checks++;
        if ({ram_A, ram_D} !== e) begin
          errors++;
          $display("FAIL wr_word got %h/%h exp %h/%h",
                   ram_A, ram_D, e[19:8], e[7:0]);
        end
      end
      checks++;
      if (wr_ready !== 1'b1) begin
        errors++;
        $display("FAIL wr_ready c=%0d got %b exp 1", c, wr_ready);
      end
      wr_valid = (pat[c % pat.size()] != 0);
      wr_data  = d[idx];
      hs = wr_valid;
      if (hs) begin
        q.push_back({ea, d[idx]});
        ea = ea + 12'd1;
        idx++;
      end
      c++;
      tick();
    end
    wr_valid = 1'b0;
    checks++;
    if (idx != n) begin
      errors++;
      $display("FAIL wr_timeout got %0d words exp %0d", idx, n);
    end
    checks++;
    if (ram_WE !== 1'b1) begin
      errors++;
      $display("FAIL wr_last_we got %b exp 1", ram_WE);
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({ram_A, ram_D} !== e) begin
        errors++;
        $display("FAIL wr_last got %h/%h exp %h/%h",
                 ram_A, ram_D, e[19:8], e[7:0]);
      end
    end
    checks++;
    if (wr_ready !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL wr_drain got rdy=%b done=%b exp 0/0",
               wr_ready, done);
    end
    tick();
    checks++;
    if ({done, ram_WE, cmd_ready} !== 3'b101) begin
      errors++;
      $display("FAIL wr_done got done/we/rdy=%b%b%b exp 101",
               done, ram_WE, cmd_ready);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (mem[a + 12'(i)] !== d[i]) begin
        errors++;
        $display("FAIL wr_mem %h got %h exp %h",
                 a + 12'(i), mem[a + 12'(i)], d[i]);
      end
    end
  endtask

  // Read burst; expected words go through a scoreboard.
  task automatic run_read(
    input logic [11:0] a,
    input logic [7:0]  d[$]
  );
    logic [7:0] sb[$];
    logic [7:0] e;
    logic       ev;
    int         n;
    n = d.size();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rd_cmd_ready got %b exp 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = a;
    cmd_len   = 8'(n - 1);
    tick();
    cmd_valid = 1'b0;
    cmd_addr  = 12'hABC;
    foreach (d[i]) sb.push_back(d[i]);
    for (int k = 0; k <= n + 1; k++) begin
      if (k < n) begin
        checks++;
        if (ram_A !== a + 12'(k)) begin
          errors++;
          $display("FAIL rd_addr k=%0d got %h exp %h",
                   k, ram_A, a + 12'(k));
        end
      end
      checks++;
      if (ram_OE !== (k <= n)) begin
        errors++;
        $display("FAIL rd_oe k=%0d got %b exp %b", k, ram_OE, k <= n);
      end
      ev = (k >= 2);
      checks++;
      if (rd_valid !== ev) begin
        errors++;
        $display("FAIL rd_valid k=%0d got %b exp %b", k, rd_valid, ev);
      end
      if (ev && sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (rd_data !== e) begin
          errors++;
          $display("FAIL rd_data k=%0d got %h exp %h", k, rd_data, e);
        end
      end
      checks++;
      if (done !== (k == n + 1)) begin
        errors++;
        $display("FAIL rd_done k=%0d got %b exp %b",
                 k, done, k == n + 1);
      end
      tick();
    end
    checks++;
    if ({done, rd_valid, sb.size() == 0} !== 3'b001) begin
      errors++;
      $display("FAIL rd_end got done=%b v=%b left=%0d exp 0/0/0",
               done, rd_valid, sb.size());
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    checks++;
    if ({ram_A, ram_D, rd_data, ram_WE, ram_OE, rd_valid, done}
        !== 32'h0) begin
      errors++;
      $display("FAIL reset_outs got A=%h D=%h R=%h %b%b%b%b exp 0",
               ram_A, ram_D, rd_data, ram_WE, ram_OE, rd_valid, done);
    end
    checks++;
    if ({cmd_ready, wr_ready} !== 2'b10) begin
      errors++;
      $display("FAIL reset_rdy got %b%b exp 10", cmd_ready, wr_ready);
    end
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 12'h300;
    cmd_len   = 8'd3;
    tick();
    wr_valid = 1'b1;
    wr_data  = 8'h99;
    tick();
    checks++;
    if ({ram_WE, ram_A} !== {1'b1, 12'h300}) begin
      errors++;
      $display("FAIL reset_pre got we=%b A=%h exp 1/300", ram_WE, ram_A);
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    cmd_valid = 1'b0;
    wr_valid  = 1'b0;
    checks++;
    if ({ram_A, ram_D, ram_WE, ram_OE, rd_valid, done}
        !== 24'h0) begin
      errors++;
      $display("FAIL reset_mid got A=%h D=%h we=%b oe=%b exp 0",
               ram_A, ram_D, ram_WE, ram_OE);
    end
    checks++;
    if ({cmd_ready, wr_ready} !== 2'b10) begin
      errors++;
      $display("FAIL reset_mid_rdy got %b%b exp 10", cmd_ready, wr_ready);
    end
  endtask

  task automatic test_write_nogap();
    run_write(12'h010, '{8'hA0, 8'hA1, 8'hA2, 8'hA3}, '{1});
  endtask

  task automatic test_write_gaps();
    run_write(12'h030, '{8'hA0, 8'hA1, 8'hA2, 8'hA3},
              '{1, 0, 1, 1, 0, 1});
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[12'h030 + 12'(i)] !== mem[12'h010 + 12'(i)]) begin
        errors++;
        $display("FAIL gap_vs_nogap i=%0d got %h exp %h", i,
                 mem[12'h030 + 12'(i)], mem[12'h010 + 12'(i)]);
      end
    end
  endtask

  task automatic test_read_wrap();
    run_write(12'hFFE, '{8'h11, 8'h22, 8'h33, 8'h44}, '{1});
    tick();
    run_read(12'hFFE, '{8'h11, 8'h22, 8'h33, 8'h44});
  endtask

  task automatic test_back_to_back();
    run_write(12'h123, '{8'h5A}, '{1});
    run_read(12'h123, '{8'h5A});
  endtask

  task automatic test_reset_mid_read();
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 12'h010;
    cmd_len   = 8'd3;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    checks++;
    if ({rd_valid, rd_data} !== {1'b1, 8'hA0}) begin
      errors++;
      $display("FAIL rmr_first got %b/%h exp 1/a0", rd_valid, rd_data);
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({rd_valid, done, ram_OE} !== 3'b000) begin
        errors++;
        $display("FAIL rmr_quiet k=%0d got v/d/oe=%b%b%b exp 000",
                 k, rd_valid, done, ram_OE);
      end
      tick();
    end
    run_read(12'h012, '{8'hA2, 8'hA3});
  endtask

  initial begin
    RST       = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    test_reset();
    test_write_nogap();
    tick();
    test_write_gaps();
    tick();
    test_read_wrap();
    tick();
    test_back_to_back();
    tick();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
